// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer engine.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    // Working width for the bias add and clamp; wide enough for any practical ACC_W/BIAS_WIDTH.
    localparam int SAT_W = 64;

    function automatic int acc_width(input int ww, input int n);
        return 2 * ww + $clog2(n) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] sum,
        input int                      width,
        input bit                      relu_en
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] r;
        max_v = $signed((64'd1 << (width - 1)) - 64'd1);
        min_v = ~max_v;
        if (sum > max_v)      r = max_v;
        else if (sum < min_v) r = min_v;
        else                  r = sum;
        if (relu_en && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: signed multiply-accumulate, bias latch, and the
// saturating/ReLU result presented combinationally for the WRITE cycle.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int WW      = 8,
    parameter int BW      = 32,
    parameter int ACC_W   = 19,
    parameter int RELU_EN = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic          bias_load_i,
    input  logic [WW-1:0] x_i,
    input  logic [WW-1:0] w_i,
    input  logic [BW-1:0] bias_i,
    output logic [BW-1:0] result_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [BW-1:0]    bias_q;
    logic signed [2*WW-1:0]  prod;
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] sat;
    logic                    unused_hi;

    assign prod = $signed(x_i) * $signed(w_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i)      acc_d = '0;
        else if (valid_i) acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            bias_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (bias_load_i) bias_q <= bias_i;
        end
    end

    // Add at full width so the clamp sees the true sum, not a wrapped one.
    assign sum       = SAT_W'(acc_q) + SAT_W'(bias_q);
    assign sat       = sat_relu(sum, BW, RELU_EN != 0);
    assign result_o  = sat[BW-1:0];
    assign unused_hi = ^sat[SAT_W-1:BW];

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer: LANES neurons per group, weights streamed one word per
// cycle from external RAM, results written per group into layer_out_o.
module fc_layer_par
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE    = 784,
    parameter int OUTPUT_SIZE   = 512,
    parameter int LANES         = 4,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int BIAS_WIDTH    = 32,
    parameter int READ_LATENCY  = 2,
    parameter int RELU_EN       = 1,
    localparam int GROUPS = OUTPUT_SIZE / LANES,
    localparam int WA_W   = (GROUPS * INPUT_SIZE > 1) ? $clog2(GROUPS * INPUT_SIZE) : 1,
    localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    output logic                                busy_o,
    output logic                                done_o,
    input  logic [INPUT_SIZE*WEIGHTS_WIDTH-1:0] inputs_i,
    output logic                                w_read_en_o,
    output logic [WA_W-1:0]                     w_read_addr_o,
    input  logic [LANES*WEIGHTS_WIDTH-1:0]      w_read_data_i,
    output logic                                b_read_en_o,
    output logic [BA_W-1:0]                     b_read_addr_o,
    input  logic [LANES*BIAS_WIDTH-1:0]         b_read_data_i,
    output logic [OUTPUT_SIZE*BIAS_WIDTH-1:0]   layer_out_o
);

    localparam int ACC_W = acc_width(WEIGHTS_WIDTH, INPUT_SIZE);
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int RL    = READ_LATENCY;

    fc_state_t              state_q, state_d;
    logic [BA_W-1:0]        g_q, g_d;
    logic [IDX_W-1:0]       i_q, i_d;
    logic [WA_W-1:0]        waddr_q, waddr_d;
    logic [2:0]             dcnt_q, dcnt_d;
    logic                   first_cyc;

    logic [RL:1]            vld_pipe;
    logic [RL:1]            first_pipe;
    logic [RL:1][IDX_W-1:0] idx_pipe;

    logic [WEIGHTS_WIDTH-1:0]               x_sel;
    logic [LANES-1:0][BIAS_WIDTH-1:0]       lane_res;
    logic [OUTPUT_SIZE*BIAS_WIDTH-1:0]      layer_out_q;

    assign first_cyc     = (state_q == STREAM) && (i_q == '0);
    assign w_read_en_o   = (state_q == STREAM);
    assign w_read_addr_o = waddr_q;
    assign b_read_en_o   = first_cyc;
    assign b_read_addr_o = g_q;
    assign busy_o        = (state_q == STREAM) || (state_q == DRAIN) || (state_q == WRITE);
    assign done_o        = (state_q == DONE);
    assign layer_out_o   = layer_out_q;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        i_d     = i_q;
        waddr_d = waddr_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = STREAM;
                    g_d     = '0;
                    i_d     = '0;
                    waddr_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                // The word address runs contiguously across groups: g*INPUT_SIZE + i.
                waddr_d = waddr_q + WA_W'(1);
                if (i_q == IDX_W'(INPUT_SIZE - 1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == 3'(RL - 1)) state_d = WRITE;
                else                      dcnt_d  = dcnt_q + 3'd1;
            end
            WRITE: begin
                if (g_q == BA_W'(GROUPS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = STREAM;
                    g_d     = g_q + BA_W'(1);
                    i_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            i_q     <= '0;
            waddr_q <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            i_q     <= i_d;
            waddr_q <= waddr_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Tags each issued read so its data, input index and bias flag line up on return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            idx_pipe   <= '0;
        end else begin
            vld_pipe[1]   <= w_read_en_o;
            first_pipe[1] <= first_cyc;
            idx_pipe[1]   <= i_q;
            for (int k = 2; k <= RL; k++) begin
                vld_pipe[k]   <= vld_pipe[k-1];
                first_pipe[k] <= first_pipe[k-1];
                idx_pipe[k]   <= idx_pipe[k-1];
            end
        end
    end

    assign x_sel = inputs_i[int'(idx_pipe[RL]) * WEIGHTS_WIDTH +: WEIGHTS_WIDTH];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fc_mac_lane #(
            .WW     (WEIGHTS_WIDTH),
            .BW     (BIAS_WIDTH),
            .ACC_W  (ACC_W),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (first_cyc),
            .valid_i    (vld_pipe[RL]),
            .bias_load_i(vld_pipe[RL] & first_pipe[RL]),
            .x_i        (x_sel),
            .w_i        (w_read_data_i[l*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]),
            .bias_i     (b_read_data_i[l*BIAS_WIDTH +: BIAS_WIDTH]),
            .result_o   (lane_res[l])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            layer_out_q <= '0;
        end else if (state_q == WRITE) begin
            for (int l = 0; l < LANES; l++)
                layer_out_q[(int'(g_q) * LANES + l) * BIAS_WIDTH +: BIAS_WIDTH] <= lane_res[l];
        end
    end

endmodule
